// File: rtl/baud_sched_if.sv
// Register-bus and tick-enable bundle between the CPU/UART side and baud_sched.
// The master side drives configuration and busy status; the slave side returns ticks and read data.
interface baud_sched_if #(
    parameter int CNT_W = 16
);
    logic             cfg_we;
    logic             cfg_re;
    logic [1:0]       cfg_addr;
    logic [CNT_W-1:0] cfg_wdata;
    logic [CNT_W-1:0] cfg_rdata;
    logic             uart_busy;
    logic             tick_os;
    logic             tick_bit;
    logic             running;

    modport master (
        output cfg_we,
        output cfg_re,
        output cfg_addr,
        output cfg_wdata,
        output uart_busy,
        input  cfg_rdata,
        input  tick_os,
        input  tick_bit,
        input  running
    );

    modport slave (
        input  cfg_we,
        input  cfg_re,
        input  cfg_addr,
        input  cfg_wdata,
        input  uart_busy,
        output cfg_rdata,
        output tick_os,
        output tick_bit,
        output running
    );
endinterface

// File: rtl/baud_sched.sv
// Programmable baud-tick scheduler: oversample and bit tick enables from a divisor,
// with divisor changes deferred to an idle bit boundary so no bit mixes two rates.
module baud_sched #(
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 54,
    parameter int OVERSAMPLE  = 16
) (
    input  logic         clk_in,
    input  logic         rst,
    baud_sched_if.slave  bus
);
    localparam int PH_W = $clog2(OVERSAMPLE);
    localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] DIV_MIN   = CNT_W'(2);
    localparam logic [CNT_W-1:0] DIV_RESET = CNT_W'(DEFAULT_DIV);

    localparam logic [1:0] ADDR_DIV    = 2'd0;
    localparam logic [1:0] ADDR_CTRL   = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_ACTIVE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RUN       = 2'd1,
        ST_WAIT_SWAP = 2'd2
    } state_t;

    state_t            state_r;
    logic [CNT_W-1:0]  active_div_r;
    logic [CNT_W-1:0]  pending_div_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [PH_W-1:0]   phase_r;
    logic              enable_r;
    logic [CNT_W-1:0]  rdata_r;

    logic              running_s;
    logic              tick_os_s;
    logic              tick_bit_s;
    logic              div_wr_s;
    logic              ctrl_wr_s;
    logic              swap_s;
    logic [CNT_W-1:0]  cnt_next_s;
    logic [PH_W-1:0]   phase_next_s;
    logic [CNT_W-1:0]  rdata_s;
    logic [CNT_W-1:0]  wdiv_s;

    // Divisors below 2 would make the tick permanently high, so they are raised to 2.
    function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] value);
        logic [CNT_W-1:0] result;
        if (value < DIV_MIN) begin
            result = DIV_MIN;
        end else begin
            result = value;
        end
        return result;
    endfunction

    // Tick decode and bus write decode.
    always_comb begin
        running_s  = (state_r != ST_IDLE);
        tick_os_s  = running_s && (cnt_r == (active_div_r - CNT_W'(1)));
        tick_bit_s = tick_os_s && (phase_r == PH_LAST);
        div_wr_s   = bus.cfg_we && (bus.cfg_addr == ADDR_DIV);
        ctrl_wr_s  = bus.cfg_we && (bus.cfg_addr == ADDR_CTRL);
        swap_s     = (state_r == ST_WAIT_SWAP) && tick_bit_s && !bus.uart_busy;
        wdiv_s     = clamp_div(bus.cfg_wdata);
    end

    // Free-running counter successors while the scheduler is active.
    always_comb begin
        cnt_next_s   = cnt_r + CNT_W'(1);
        phase_next_s = phase_r;
        if (tick_os_s) begin
            cnt_next_s = {CNT_W{1'b0}};
            if (phase_r == PH_LAST) begin
                phase_next_s = {PH_W{1'b0}};
            end else begin
                phase_next_s = phase_r + PH_W'(1);
            end
        end else begin
            phase_next_s = phase_r;
        end
    end

    // Register read multiplexer.
    always_comb begin
        rdata_s = {CNT_W{1'b0}};
        case (bus.cfg_addr)
            ADDR_DIV:    rdata_s = pending_div_r;
            ADDR_CTRL:   rdata_s = {{(CNT_W-1){1'b0}}, enable_r};
            ADDR_STATUS: rdata_s = {{(CNT_W-3){1'b0}}, bus.uart_busy, running_s,
                                    (state_r == ST_WAIT_SWAP)};
            ADDR_ACTIVE: rdata_s = active_div_r;
            default:     rdata_s = {CNT_W{1'b0}};
        endcase
    end

    // Scheduler state machine, divisor bookkeeping and registered read data.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            active_div_r  <= DIV_RESET;
            pending_div_r <= {CNT_W{1'b0}};
            cnt_r         <= {CNT_W{1'b0}};
            phase_r       <= {PH_W{1'b0}};
            enable_r      <= 1'b0;
            rdata_r       <= {CNT_W{1'b0}};
        end else begin
            if (bus.cfg_re) begin
                rdata_r <= rdata_s;
            end
            if (ctrl_wr_s) begin
                enable_r <= bus.cfg_wdata[0];
            end
            case (state_r)
                ST_IDLE: begin
                    cnt_r   <= {CNT_W{1'b0}};
                    phase_r <= {PH_W{1'b0}};
                    if (div_wr_s) begin
                        active_div_r <= wdiv_s;
                    end
                    if (ctrl_wr_s && bus.cfg_wdata[0]) begin
                        state_r <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (ctrl_wr_s && !bus.cfg_wdata[0]) begin
                        state_r <= ST_IDLE;
                        cnt_r   <= {CNT_W{1'b0}};
                        phase_r <= {PH_W{1'b0}};
                    end else begin
                        cnt_r   <= cnt_next_s;
                        phase_r <= phase_next_s;
                        if (div_wr_s) begin
                            pending_div_r <= wdiv_s;
                            state_r       <= ST_WAIT_SWAP;
                        end
                    end
                end
                ST_WAIT_SWAP: begin
                    if (ctrl_wr_s && !bus.cfg_wdata[0]) begin
                        // Disabling commits the pending divisor so it is in force on re-enable.
                        active_div_r <= pending_div_r;
                        state_r      <= ST_IDLE;
                        cnt_r        <= {CNT_W{1'b0}};
                        phase_r      <= {PH_W{1'b0}};
                    end else if (swap_s) begin
                        active_div_r <= pending_div_r;
                        cnt_r        <= {CNT_W{1'b0}};
                        phase_r      <= {PH_W{1'b0}};
                        if (div_wr_s) begin
                            pending_div_r <= wdiv_s;
                        end else begin
                            state_r <= ST_RUN;
                        end
                    end else begin
                        cnt_r   <= cnt_next_s;
                        phase_r <= phase_next_s;
                        if (div_wr_s) begin
                            pending_div_r <= wdiv_s;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= {CNT_W{1'b0}};
                    phase_r <= {PH_W{1'b0}};
                end
            endcase
        end
    end

    assign bus.cfg_rdata = rdata_r;
    assign bus.tick_os   = tick_os_s;
    assign bus.tick_bit  = tick_bit_s;
    assign bus.running   = running_s;
endmodule

// File: tb/tb_baud_sched.sv
// Directed bench for baud_sched: tick spacing, divisor clamp, deferred swap, busy hold-off,
// disable during a pending swap and asynchronous reset.
module tb_baud_sched;
    localparam logic [1:0] A_DIV    = 2'd0;
    localparam logic [1:0] A_CTRL   = 2'd1;
    localparam logic [1:0] A_STATUS = 2'd2;
    localparam logic [1:0] A_ACTIVE = 2'd3;

    logic clk_in = 1'b0;
    logic rst    = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   stray   = 0;
    int   tq[$];
    bit   bq[$];

    baud_sched_if #(.CNT_W(16)) bif();

    baud_sched #(.CNT_W(16), .DEFAULT_DIV(54), .OVERSAMPLE(16)) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .bus    (bif.slave)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    // Tick log: cycle index of every tick_os and whether tick_bit came with it.
    always @(negedge clk_in) begin
        if (bif.tick_os) begin
            tq.push_back(cyc);
            bq.push_back(bif.tick_bit);
        end
        if (bif.tick_bit && !bif.tick_os) stray++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference tick schedule: first tick at first_c, spacing g_old until swap_c, then g_new.
    function automatic int model_errors(input int first_c, input int swap_c, input int g_old,
                                        input int g_new, input int limit);
        int errs = 0;
        int exp_c = first_c;
        int ph = 0;
        int g = g_old;
        int k = 0;
        while (exp_c < limit) begin
            if (k >= tq.size()) begin
                errs++;
            end else begin
                if (tq[k] != exp_c) errs++;
                if (bq[k] != (ph == 15)) errs++;
            end
            k++;
            if (exp_c == swap_c) begin
                g = g_new;
                ph = 0;
            end else begin
                ph = (ph + 1) % 16;
            end
            exp_c += g;
        end
        for (int i = k; i < tq.size(); i++) if (tq[i] < limit) errs++;
        return errs;
    endfunction

    task automatic do_reset();
        @(negedge clk_in);
        rst = 1'b1;
        bif.cfg_we = 1'b0;
        bif.cfg_re = 1'b0;
        bif.uart_busy = 1'b0;
        repeat (2) @(negedge clk_in);
        rst = 1'b0;
        tq.delete();
        bq.delete();
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [15:0] d);
        @(negedge clk_in);
        bif.cfg_we = 1'b1;
        bif.cfg_addr = a;
        bif.cfg_wdata = d;
        @(negedge clk_in);
        bif.cfg_we = 1'b0;
    endtask

    task automatic cfg_read(input logic [1:0] a, output logic [15:0] d);
        @(negedge clk_in);
        bif.cfg_re = 1'b1;
        bif.cfg_addr = a;
        @(negedge clk_in);
        bif.cfg_re = 1'b0;
        d = bif.cfg_rdata;
    endtask

    task automatic test_reset();
        logic [15:0] d;
        @(negedge clk_in);
        n_tests++;
        if ({bif.tick_os, bif.tick_bit, bif.running} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 000", {bif.tick_os, bif.tick_bit, bif.running});
        end
        n_tests++;
        if (bif.cfg_rdata !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_rdata: got %h expected 0000", bif.cfg_rdata);
        end
        do_reset();
        cfg_read(A_ACTIVE, d);
        n_tests++;
        if (d !== 16'd54) begin n_fail++; $display("FAIL reset_active: got %0d expected 54", d); end
        cfg_read(A_DIV, d);
        n_tests++;
        if (d !== 16'd0) begin n_fail++; $display("FAIL reset_pending: got %0d expected 0", d); end
        cfg_read(A_CTRL, d);
        n_tests++;
        if (d !== 16'd0) begin n_fail++; $display("FAIL reset_ctrl: got %0d expected 0", d); end
        cfg_write(A_ACTIVE, 16'd7);
        cfg_write(A_STATUS, 16'd5);
        cfg_read(A_ACTIVE, d);
        n_tests++;
        if (d !== 16'd54) begin n_fail++; $display("FAIL ro_active: got %0d expected 54", d); end
        repeat (3) @(negedge clk_in);
        n_tests++;
        if (bif.cfg_rdata !== 16'd54) begin n_fail++; $display("FAIL rdata_hold: got %0d expected 54", bif.cfg_rdata); end
        bif.uart_busy = 1'b1;
        cfg_read(A_STATUS, d);
        bif.uart_busy = 1'b0;
        n_tests++;
        if (d !== 16'h0004) begin n_fail++; $display("FAIL status_idle_busy: got %h expected 0004", d); end
    endtask

    task automatic test_basic_ticks();
        logic [15:0] d;
        int e;
        int errs;
        int nbits;
        do_reset();
        cfg_write(A_DIV, 16'd4);
        cfg_write(A_CTRL, 16'd1);
        e = cyc;
        cfg_read(A_STATUS, d);
        n_tests++;
        if (d !== 16'h0002) begin n_fail++; $display("FAIL status_run: got %h expected 0002", d); end
        cfg_read(A_CTRL, d);
        n_tests++;
        if (d !== 16'h0001) begin n_fail++; $display("FAIL ctrl_read: got %h expected 0001", d); end
        while (cyc < e + 150) @(negedge clk_in);
        errs = model_errors(e + 3, -1, 4, 4, cyc);
        n_tests++;
        if (errs !== 0) begin n_fail++; $display("FAIL div4_schedule: got %0d errors expected 0", errs); end
        nbits = 0;
        foreach (bq[i]) if (bq[i] && tq[i] < e + 150) nbits++;
        n_tests++;
        if (nbits !== 2) begin n_fail++; $display("FAIL div4_bit_count: got %0d expected 2", nbits); end
    endtask

    task automatic test_clamp();
        logic [15:0] d;
        int e;
        int errs;
        do_reset();
        cfg_write(A_DIV, 16'd0);
        cfg_read(A_DIV, d);
        n_tests++;
        if (d !== 16'd0) begin n_fail++; $display("FAIL clamp_pending_unused: got %0d expected 0", d); end
        @(negedge clk_in);
        bif.cfg_re = 1'b1;
        bif.cfg_addr = A_ACTIVE;
        #1;
        n_tests++;
        if (bif.cfg_rdata !== 16'd0) begin n_fail++; $display("FAIL read_latency: got %0d expected 0", bif.cfg_rdata); end
        @(negedge clk_in);
        bif.cfg_re = 1'b0;
        n_tests++;
        if (bif.cfg_rdata !== 16'd2) begin n_fail++; $display("FAIL clamp_active: got %0d expected 2", bif.cfg_rdata); end
        cfg_write(A_CTRL, 16'd1);
        e = cyc;
        while (cyc < e + 40) @(negedge clk_in);
        errs = model_errors(e + 1, -1, 2, 2, cyc);
        n_tests++;
        if (errs !== 0) begin n_fail++; $display("FAIL clamp_schedule: got %0d errors expected 0", errs); end
    endtask

    task automatic test_deferred_swap();
        logic [15:0] d;
        int e;
        int errs;
        do_reset();
        cfg_write(A_DIV, 16'd4);
        cfg_write(A_CTRL, 16'd1);
        e = cyc;
        repeat (100) @(negedge clk_in);
        cfg_write(A_DIV, 16'd6);
        cfg_write(A_DIV, 16'd8);
        cfg_read(A_STATUS, d);
        n_tests++;
        if (d !== 16'h0003) begin n_fail++; $display("FAIL swap_pending_status: got %h expected 0003", d); end
        cfg_read(A_ACTIVE, d);
        n_tests++;
        if (d !== 16'd4) begin n_fail++; $display("FAIL swap_active_before: got %0d expected 4", d); end
        while (cyc < e + 140) @(negedge clk_in);
        cfg_read(A_STATUS, d);
        n_tests++;
        if (d !== 16'h0002) begin n_fail++; $display("FAIL swap_done_status: got %h expected 0002", d); end
        cfg_read(A_ACTIVE, d);
        n_tests++;
        if (d !== 16'd8) begin n_fail++; $display("FAIL swap_active_after: got %0d expected 8", d); end
        while (cyc < e + 260) @(negedge clk_in);
        errs = model_errors(e + 3, e + 127, 4, 8, cyc);
        n_tests++;
        if (errs !== 0) begin n_fail++; $display("FAIL swap_schedule: got %0d errors expected 0", errs); end
    endtask

    task automatic test_busy_holdoff();
        logic [15:0] d;
        int e;
        int errs;
        do_reset();
        cfg_write(A_DIV, 16'd4);
        cfg_write(A_CTRL, 16'd1);
        e = cyc;
        bif.uart_busy = 1'b1;
        repeat (18) @(negedge clk_in);
        cfg_write(A_DIV, 16'd8);
        while (cyc < e + 140) @(negedge clk_in);
        cfg_read(A_STATUS, d);
        n_tests++;
        if (d !== 16'h0007) begin n_fail++; $display("FAIL busy_status: got %h expected 0007", d); end
        cfg_read(A_ACTIVE, d);
        n_tests++;
        if (d !== 16'd4) begin n_fail++; $display("FAIL busy_no_swap: got %0d expected 4", d); end
        while (cyc < e + 150) @(negedge clk_in);
        bif.uart_busy = 1'b0;
        while (cyc < e + 300) @(negedge clk_in);
        errs = model_errors(e + 3, e + 191, 4, 8, cyc);
        n_tests++;
        if (errs !== 0) begin n_fail++; $display("FAIL busy_schedule: got %0d errors expected 0", errs); end
        cfg_read(A_ACTIVE, d);
        n_tests++;
        if (d !== 16'd8) begin n_fail++; $display("FAIL busy_active_after: got %0d expected 8", d); end
    endtask

    task automatic test_disable_wait_swap();
        logic [15:0] d;
        int e;
        int dis;
        int errs;
        int late;
        do_reset();
        cfg_write(A_DIV, 16'd4);
        cfg_write(A_CTRL, 16'd1);
        e = cyc;
        repeat (10) @(negedge clk_in);
        cfg_write(A_DIV, 16'd10);
        repeat (18) @(negedge clk_in);
        cfg_write(A_CTRL, 16'd0);
        dis = cyc;
        n_tests++;
        if (bif.running !== 1'b0) begin n_fail++; $display("FAIL disable_running: got %b expected 0", bif.running); end
        repeat (50) @(negedge clk_in);
        errs = model_errors(e + 3, -1, 4, 4, dis);
        n_tests++;
        if (errs !== 0) begin n_fail++; $display("FAIL disable_schedule: got %0d errors expected 0", errs); end
        late = 0;
        foreach (tq[i]) if (tq[i] >= dis) late++;
        n_tests++;
        if (late !== 0) begin n_fail++; $display("FAIL disable_ticks_stop: got %0d late ticks expected 0", late); end
        cfg_read(A_ACTIVE, d);
        n_tests++;
        if (d !== 16'd10) begin n_fail++; $display("FAIL disable_active: got %0d expected 10", d); end
        cfg_read(A_STATUS, d);
        n_tests++;
        if (d !== 16'h0000) begin n_fail++; $display("FAIL disable_status: got %h expected 0000", d); end
    endtask

    task automatic test_async_reset();
        logic [15:0] d;
        int e;
        bit found;
        do_reset();
        cfg_write(A_DIV, 16'd4);
        cfg_write(A_CTRL, 16'd1);
        cfg_read(A_ACTIVE, d);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk_in);
            if (bif.tick_os) found = 1'b1;
        end
        n_tests++;
        if (found !== 1'b1) begin n_fail++; $display("FAIL areset_tick_seen: got %b expected 1", found); end
        #1 rst = 1'b1;
        #1;
        n_tests++;
        if ({bif.tick_os, bif.tick_bit, bif.running} !== 3'b000) begin
            n_fail++;
            $display("FAIL areset_outputs: got %b expected 000", {bif.tick_os, bif.tick_bit, bif.running});
        end
        n_tests++;
        if (bif.cfg_rdata !== 16'h0000) begin n_fail++; $display("FAIL areset_rdata: got %h expected 0000", bif.cfg_rdata); end
        @(negedge clk_in);
        rst = 1'b0;
        tq.delete();
        bq.delete();
        cfg_read(A_ACTIVE, d);
        n_tests++;
        if (d !== 16'd54) begin n_fail++; $display("FAIL areset_active: got %0d expected 54", d); end
        repeat (100) @(negedge clk_in);
        n_tests++;
        if (tq.size() !== 0) begin n_fail++; $display("FAIL areset_no_ticks: got %0d ticks expected 0", tq.size()); end
        cfg_write(A_CTRL, 16'd1);
        e = cyc;
        while (cyc < e + 60) @(negedge clk_in);
        n_tests++;
        if (tq.size() == 0 || tq[0] !== e + 53) begin
            n_fail++;
            $display("FAIL areset_reenable_first: got %0d ticks first %0d expected first %0d",
                     tq.size(), (tq.size() == 0) ? -1 : tq[0], e + 53);
        end
        n_tests++;
        if (stray !== 0) begin n_fail++; $display("FAIL stray_tick_bit: got %0d expected 0", stray); end
    endtask

    initial begin
        bif.cfg_we = 1'b0;
        bif.cfg_re = 1'b0;
        bif.cfg_addr = 2'd0;
        bif.cfg_wdata = 16'd0;
        bif.uart_busy = 1'b0;
        test_reset();
        test_basic_ticks();
        test_clamp();
        test_deferred_swap();
        test_busy_holdoff();
        test_disable_wait_swap();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
